dm_port_arbiter: RTL and testbench

//  - Shares the single-port data-memory BRAM (1-cycle read latency) between two requesters.
//  - Port 0 is the pipeline MEM stage (load/store); port 1 is the loader/debug DMA port.
//  - Issues at most one memory access per cycle and routes read data back to the owner.
//  - Drives a stall to the pipeline while its access is held off.

---
 rtl/dm_port_arbiter.sv | 131 +++++++++++++
 tb/tb_dm_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Single-port data-memory arbiter: pipeline MEM stage (port 0) vs loader/debug DMA (port 1).
// Optional build macro DM_ARB_ROUND_ROBIN_EN selects round-robin ties; default is fixed priority with starvation override.
//
// Handshake: pX_req is a level held with stable fields until pX_gnt is seen high in the
// same cycle; a cycle with req & gnt transfers one access. Reads return pX_rvalid/pX_rdata
// exactly one cycle after the grant, with no backpressure on the return path.
module dm_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int SCW         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           p0_req,
  input  logic           p0_we,
  input  logic [AW-1:0]  p0_addr,
  input  logic [DW-1:0]  p0_wdata,
  output logic           p0_gnt,
  output logic           p0_stall,
  output logic           p0_rvalid,
  output logic [DW-1:0]  p0_rdata,
  input  logic           p1_req,
  input  logic           p1_we,
  input  logic [AW-1:0]  p1_addr,
  input  logic [DW-1:0]  p1_wdata,
  output logic           p1_gnt,
  output logic           p1_rvalid,
  output logic [DW-1:0]  p1_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  output logic           dbg_last_winner,
  output logic [SCW-1:0] dbg_starve_cnt
);

  typedef enum logic {
    LW_P0 = 1'b0,
    LW_P1 = 1'b1
  } winner_e;

  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  winner_e        last_winner_q, last_winner_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic           rd_pend_q, rd_pend_d;
  winner_e        rd_owner_q, rd_owner_d;
  logic           grant0, grant1;

  // Winner selection; reset forces no grant so nothing reaches the BRAM.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        if (last_winner_q == LW_P0) grant1 = 1'b1;
        else                        grant0 = 1'b1;
`else
        if (starve_cnt_q == STARVE_MAX) grant1 = 1'b1;
        else                            grant0 = 1'b1;
`endif
      end else begin
        grant0 = p0_req;
        grant1 = p1_req;
      end
    end
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (grant0)      last_winner_d = LW_P0;
    else if (grant1) last_winner_d = LW_P1;

    starve_cnt_d = '0;
`ifndef DM_ARB_ROUND_ROBIN_EN
    if (p1_req && !grant1 && starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    else if (p1_req && !grant1)                          starve_cnt_d = starve_cnt_q;
`endif

    rd_pend_d  = (grant0 && !p0_we) || (grant1 && !p1_we);
    rd_owner_d = grant1 ? LW_P1 : LW_P0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= LW_P1;
      starve_cnt_q  <= '0;
      rd_pend_q     <= 1'b0;
      rd_owner_q    <= LW_P0;
    end else begin
      last_winner_q <= last_winner_d;
      starve_cnt_q  <= starve_cnt_d;
      rd_pend_q     <= rd_pend_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

  always_comb begin
    mem_en    = grant0 | grant1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (grant1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // A read in flight when reset arrives is dropped: its return cycle is masked.
  assign p0_gnt    = grant0;
  assign p1_gnt    = grant1;
  assign p0_stall  = p0_req & ~grant0;
  assign p0_rvalid = rd_pend_q & (rd_owner_q == LW_P0) & ~reset;
  assign p1_rvalid = rd_pend_q & (rd_owner_q == LW_P1) & ~reset;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  assign dbg_last_winner = last_winner_q;
  assign dbg_starve_cnt  = starve_cnt_q;

  a_one_grant: assert property (@(posedge clk) !(grant0 && grant1));

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios with literal expectations, then random two-port traffic.
// Build with DM_ARB_ROUND_ROBIN_EN defined to exercise the round-robin tie rule.
module tb_dm_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int STARVE_LIMIT = 4;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic clk, reset;
  logic p0_req, p0_we, p0_gnt, p0_stall, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic dbg_last_winner;
  logic [SCW-1:0] dbg_starve_cnt;

  int checks = 0;
  int errors = 0;

  dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dbg_last_winner(dbg_last_winner), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM stand-in: 64 words, 1-cycle read latency
  logic [DW-1:0] bram [64];
  initial begin
    for (int i = 0; i < 64; i++) bram[i] = DW'(i * 3 + 1);
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: contents, pending read data, arbitration history
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q[$];
  bit m_last = 1'b1;
  int m_streak = 0;
  bit m_pend = 1'b0;
  bit m_owner = 1'b0;
  initial for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i * 3 + 1);

  // Scoreboard: every cycle, compare all outputs against the model
  always @(negedge clk) begin
    bit e_g0, e_g1, e_rv0, e_rv1, e_we;
    logic [DW-1:0] e_rd, e_wd;
    logic [AW-1:0] e_ad;
    e_g0 = 1'b0; e_g1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd = '0;
    if (!reset) begin
      if (p0_req && p1_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        e_g1 = (m_last == 1'b0);
`else
        e_g1 = (m_streak >= STARVE_LIMIT);
`endif
        e_g0 = !e_g1;
      end else begin
        e_g0 = p0_req;
        e_g1 = p1_req;
      end
    end
    if (m_pend) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL model_queue at %0t: empty expected queue", $time);
      end else begin
        e_rd = exp_q.pop_front();
      end
      if (!reset) begin
        e_rv0 = (m_owner == 1'b0);
        e_rv1 = (m_owner == 1'b1);
      end
    end
    e_we = e_g0 ? p0_we : (e_g1 ? p1_we : 1'b0);
    e_ad = e_g0 ? p0_addr : (e_g1 ? p1_addr : '0);
    e_wd = e_g0 ? p0_wdata : (e_g1 ? p1_wdata : '0);

    check("p0_gnt", 32'(p0_gnt), 32'(e_g0));
    check("p1_gnt", 32'(p1_gnt), 32'(e_g1));
    check("p0_stall", 32'(p0_stall), 32'(p0_req && !e_g0));
    check("mem_en", 32'(mem_en), 32'(e_g0 || e_g1));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_ad));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check("p0_rvalid", 32'(p0_rvalid), 32'(e_rv0));
    check("p1_rvalid", 32'(p1_rvalid), 32'(e_rv1));
    check("p0_rdata", 32'(p0_rdata), 32'(e_rv0 ? e_rd : '0));
    check("p1_rdata", 32'(p1_rdata), 32'(e_rv1 ? e_rd : '0));
    check("last_winner", 32'(dbg_last_winner), 32'(m_last));
    check("starve_cnt", 32'(dbg_starve_cnt), 32'(m_streak));

    // Advance model to the state after the coming edge
    m_pend = 1'b0;
    if (reset) begin
      m_last = 1'b1;
      m_streak = 0;
    end else begin
      if (e_g0 || e_g1) begin
        m_last = e_g1;
        if (e_we) ref_mem[e_ad[5:0]] = e_wd;
        else begin
          exp_q.push_back(ref_mem[e_ad[5:0]]);
          m_pend = 1'b1;
          m_owner = e_g1;
        end
      end
`ifndef DM_ARB_ROUND_ROBIN_EN
      if (p1_req && !e_g1) m_streak = m_streak + 1;
      else                 m_streak = 0;
`endif
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios, then random traffic
  initial begin
    logic [5:0] g1_pat, g1_seen;
    bit g0, g1;
`ifdef DM_ARB_ROUND_ROBIN_EN
    g1_pat = 6'b101010;
`else
    g1_pat = 6'b010000;
`endif
    g1_seen = '0;
    reset = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    next_cycle();

    // Reset held with p0 requesting
    p0_req = 1'b1; p0_addr = 16'h0004;
    repeat (3) begin
      @(negedge clk);
      check("rst_p0_gnt", 32'(p0_gnt), 32'h0);
      check("rst_p0_stall", 32'(p0_stall), 32'h1);
      check("rst_mem_en", 32'(mem_en), 32'h0);
      check("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
      next_cycle();
    end

    // Write then read back through port 0
    reset = 1'b0;
    p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    @(negedge clk);
    check("wr_gnt", 32'(p0_gnt), 32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h0010);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    next_cycle();
    p0_we = 1'b0;
    @(negedge clk);
    check("rd_gnt", 32'(p0_gnt), 32'h1);
    check("rd_no_early_rvalid", 32'(p0_rvalid), 32'h0);
    next_cycle();
    p0_req = 1'b0;
    @(negedge clk);
    check("rd_rvalid", 32'(p0_rvalid), 32'h1);
    check("rd_rdata", 32'(p0_rdata), 32'hBEEF);
    check("rd_p1_quiet", 32'(p1_rvalid), 32'h0);
    next_cycle();

    // Port 1 read cut off by reset on its return cycle
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0021;
    @(negedge clk);
    check("p1_rd_gnt", 32'(p1_gnt), 32'h1);
    next_cycle();
    p1_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("p1_rvalid_dropped", 32'(p1_rvalid), 32'h0);
    check("p1_rdata_dropped", 32'(p1_rdata), 32'h0);
    next_cycle();

    // Both ports read every cycle for 6 cycles
    reset = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0001;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0002;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g1_seen[k] = p1_gnt;
      check("tie_p1_gnt", 32'(p1_gnt), 32'(g1_pat[k]));
      check("tie_p0_gnt", 32'(p0_gnt), 32'(!g1_pat[k]));
      if (k > 0) begin
        check("tie_p1_rvalid", 32'(p1_rvalid), 32'(g1_pat[k-1]));
        check("tie_p0_rvalid", 32'(p0_rvalid), 32'(!g1_pat[k-1]));
      end
      if (k == 5) check("tie_starve_after", 32'(dbg_starve_cnt), 32'h0);
      next_cycle();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    check("tie_last_rvalid", 32'(p1_rvalid), 32'(g1_pat[5]));
    check("tie_pattern", 32'(g1_seen), 32'(g1_pat));
    next_cycle();

    // Random traffic; a requester only changes its request after seeing a grant
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = p0_gnt;
      g1 = p1_gnt;
      next_cycle();
      reset = ($urandom_range(0, 199) == 0);
      if (!p0_req || g0) begin
        p0_req = ($urandom_range(0, 3) != 0);
        p0_we = 1'($urandom_range(0, 1));
        p0_addr = AW'($urandom_range(0, 63));
        p0_wdata = DW'($urandom);
      end
      if (!p1_req || g1) begin
        p1_req = ($urandom_range(0, 2) != 0);
        p1_we = 1'($urandom_range(0, 1));
        p1_addr = AW'($urandom_range(0, 63));
        p1_wdata = DW'($urandom);
      end
    end
    reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
